// File: rtl/exc_pkg.sv
// Shared encodings for the exception/CSR commit stage: instruction kinds,
// exception codes, CSR numbers and FSM states.
package exc_pkg;

    typedef enum logic [2:0] {
        KIND_NONE    = 3'd0,
        KIND_CSRRD   = 3'd1,
        KIND_CSRWR   = 3'd2,
        KIND_CSRXCHG = 3'd3,
        KIND_ERTN    = 3'd4
    } wb_kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [13:0] CSR_ERA = 14'h006;

    // Reserved encodings 5-7 collapse to NONE.
    function automatic wb_kind_e decode_kind(input logic [2:0] raw);
        case (raw)
            3'd1:    decode_kind = KIND_CSRRD;
            3'd2:    decode_kind = KIND_CSRWR;
            3'd3:    decode_kind = KIND_CSRXCHG;
            3'd4:    decode_kind = KIND_ERTN;
            default: decode_kind = KIND_NONE;
        endcase
    endfunction

endpackage

// File: rtl/exc_perf_cnt.sv
// Free-running exception and interrupt event counters, wrapping at 2^32.
// Latency: count visible the cycle after the event. Backpressure: none.
// Built only when EXC_COMMIT_PERF_EN is defined.
module exc_perf_cnt (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_inc,
    input  logic        int_inc,
    output logic [31:0] perf_exc_cnt,
    output logic [31:0] perf_int_cnt
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_exc_cnt <= 32'd0;
            perf_int_cnt <= 32'd0;
        end else begin
            if (exc_inc) perf_exc_cnt <= perf_exc_cnt + 32'd1;
            if (int_inc) perf_int_cnt <= perf_int_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/exc_commit.sv
// Commit stage resolving interrupts, exceptions, ERTN and CSR ops; optional perf counters under EXC_COMMIT_PERF_EN.
// Latency: CSR/exception side effects combinational on accept; rf write and flush_pc one cycle later.
// Backpressure: wb_ready drops while a flush is outstanding, until flush_ack is seen.
module exc_commit
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc_in,
    input  logic [2:0]  wb_kind,
    input  logic [13:0] wb_csr_num_in,
    input  logic [31:0] wb_rd_value,
    input  logic [31:0] wb_rj_value,
    input  logic        wb_ex_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_vaddr_in,
    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    input  logic [31:0] csr_eentry,
    input  logic        has_int,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        flush_req,
    output logic [31:0] flush_pc,
    input  logic        flush_ack
`ifdef EXC_COMMIT_PERF_EN
    ,
    output logic [31:0] perf_exc_cnt,
    output logic [31:0] perf_int_cnt
`endif
);

    state_e   state_q, state_d;
    wb_kind_e kind;
    logic     accept;
    logic     take_int, take_exc, take_ertn, take_csr, csr_write;

    assign kind     = decode_kind(wb_kind);
    assign wb_ready = (state_q == ST_IDLE);
    // Gated by resetn so no pulse escapes while reset is held.
    assign accept   = wb_valid & wb_ready & resetn;

    assign take_int  = accept & has_int;
    assign take_exc  = accept & ~has_int & wb_ex_in;
    assign take_ertn = accept & ~has_int & ~wb_ex_in & (kind == KIND_ERTN);
    assign take_csr  = accept & ~has_int & ~wb_ex_in &
                       ((kind == KIND_CSRRD) | (kind == KIND_CSRWR) | (kind == KIND_CSRXCHG));
    assign csr_write = take_csr & ((kind == KIND_CSRWR) | (kind == KIND_CSRXCHG));

    always_comb begin
        wb_ex       = 1'b0;
        wb_ecode    = 6'd0;
        wb_esubcode = 9'd0;
        wb_vaddr    = 32'd0;
        wb_pc       = wb_pc_in;
        ertn_flush  = take_ertn;
        csr_re      = take_ertn | take_csr;
        csr_num     = 14'd0;
        csr_we      = csr_write;
        csr_wmask   = 32'd0;
        csr_wvalue  = 32'd0;
        if (take_int) begin
            wb_ex    = 1'b1;
            wb_ecode = ECODE_INT;
        end else if (take_exc) begin
            wb_ex       = 1'b1;
            wb_ecode    = wb_ecode_in;
            wb_esubcode = wb_esubcode_in;
            wb_vaddr    = wb_vaddr_in;
        end
        if (take_ertn)
            csr_num = CSR_ERA;
        else if (take_csr)
            csr_num = wb_csr_num_in;
        if (csr_write) begin
            csr_wvalue = wb_rd_value;
            csr_wmask  = (kind == KIND_CSRXCHG) ? wb_rj_value : 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (take_int | take_exc | take_ertn | csr_write) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    assign flush_req = (state_q == ST_FLUSH);

    // flush_pc only moves on an accept, so it stays stable through FLUSH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_wdata <= 32'd0;
            flush_pc <= 32'd0;
        end else begin
            rf_we <= take_csr;
            if (take_csr)
                rf_wdata <= csr_rvalue;
            if (take_int | take_exc)
                flush_pc <= csr_eentry;
            else if (take_ertn)
                flush_pc <= csr_rvalue;
            else if (csr_write)
                flush_pc <= wb_pc_in + 32'd4;
        end
    end

`ifdef EXC_COMMIT_PERF_EN
    exc_perf_cnt u_perf_cnt (
        .clk          (clk),
        .resetn       (resetn),
        .exc_inc      (take_exc),
        .int_inc      (take_int),
        .perf_exc_cnt (perf_exc_cnt),
        .perf_int_cnt (perf_int_cnt)
    );
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: comb outputs checked on accept, rf writes and
// flush targets checked through scoreboard queues by a monitor.
module tb_exc_commit;
    import exc_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_pc_in, wb_rd_value, wb_rj_value, wb_vaddr_in;
    logic [2:0]  wb_kind;
    logic [13:0] wb_csr_num_in;
    logic        wb_ex_in;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        ertn_flush;
    logic [31:0] csr_eentry;
    logic        has_int;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush_ack;
`ifdef EXC_COMMIT_PERF_EN
    logic [31:0] perf_exc_cnt, perf_int_cnt;
`endif

    exc_commit dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc_in(wb_pc_in), .wb_kind(wb_kind), .wb_csr_num_in(wb_csr_num_in),
        .wb_rd_value(wb_rd_value), .wb_rj_value(wb_rj_value),
        .wb_ex_in(wb_ex_in), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
        .wb_vaddr_in(wb_vaddr_in), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .csr_eentry(csr_eentry), .has_int(has_int),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .flush_req(flush_req),
        .flush_pc(flush_pc), .flush_ack(flush_ack)
`ifdef EXC_COMMIT_PERF_EN
        , .perf_exc_cnt(perf_exc_cnt), .perf_int_cnt(perf_int_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_exc = 0;
    int          exp_int = 0;
    logic [31:0] rf_q[$];
    logic [31:0] flush_q[$];
    logic        flush_seen = 1'b0;
    logic [31:0] flush_held = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pops scoreboard entries as the DUT produces rf writes / flush requests.
    always @(posedge clk) begin
        #2;
        if (rf_we) begin
            if (rf_q.size() == 0) chk("rf_we_unexpected", 32'd1, 32'd0);
            else chk("rf_wdata", rf_wdata, rf_q.pop_front());
        end
        if (flush_req && !flush_seen) begin
            flush_seen = 1'b1;
            flush_held = flush_pc;
            if (flush_q.size() == 0) chk("flush_unexpected", 32'd1, 32'd0);
            else chk("flush_pc", flush_pc, flush_q.pop_front());
        end else if (flush_req) begin
            chk("flush_pc_stable", flush_pc, flush_held);
        end else begin
            flush_seen = 1'b0;
        end
    end

    task automatic idle_inputs();
        wb_valid = 0; wb_kind = 3'd0; wb_pc_in = 0; wb_csr_num_in = 0;
        wb_rd_value = 0; wb_rj_value = 0; wb_ex_in = 0; wb_ecode_in = 0;
        wb_esubcode_in = 0; wb_vaddr_in = 0; has_int = 0; csr_rvalue = 0;
        csr_eentry = 0; flush_ack = 0;
    endtask

    // Drive one instruction for one cycle, check comb outputs, push scoreboard entries.
    task automatic issue(input logic [2:0] kind, input logic [31:0] pc, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj, input logic ex,
                         input logic [5:0] ec, input logic [8:0] esub, input logic [31:0] va,
                         input logic irq, input logic [31:0] rval, input logic [31:0] eentry,
                         output logic exp_flush);
        logic t_int, t_exc, t_ertn, t_csr, t_we;
        @(negedge clk);
        wb_valid = 1; wb_kind = kind; wb_pc_in = pc; wb_csr_num_in = num;
        wb_rd_value = rd; wb_rj_value = rj; wb_ex_in = ex; wb_ecode_in = ec;
        wb_esubcode_in = esub; wb_vaddr_in = va; has_int = irq;
        csr_rvalue = rval; csr_eentry = eentry;
        t_int  = irq;
        t_exc  = !irq && ex;
        t_ertn = !irq && !ex && kind == 3'd4;
        t_csr  = !irq && !ex && (kind == 3'd1 || kind == 3'd2 || kind == 3'd3);
        t_we   = t_csr && kind != 3'd1;
        #1;
        chk("wb_ready_idle", wb_ready, 1);
        chk("wb_ex", wb_ex, t_int | t_exc);
        chk("csr_re", csr_re, t_ertn | t_csr);
        chk("csr_we", csr_we, t_we);
        chk("ertn_flush", ertn_flush, t_ertn);
        if (t_int | t_exc) begin
            chk("wb_ecode", wb_ecode, t_int ? 6'h0 : ec);
            chk("wb_esubcode", wb_esubcode, t_int ? 9'h0 : esub);
            chk("wb_pc", wb_pc, pc);
            if (t_exc) chk("wb_vaddr", wb_vaddr, va);
        end
        if (t_ertn) chk("csr_num_era", csr_num, 14'h006);
        if (t_csr)  chk("csr_num", csr_num, num);
        if (t_we) begin
            chk("csr_wmask", csr_wmask, kind == 3'd3 ? rj : 32'hFFFF_FFFF);
            chk("csr_wvalue", csr_wvalue, rd);
        end
        if (t_csr) rf_q.push_back(rval);
        if (t_int | t_exc) flush_q.push_back(eentry);
        else if (t_ertn) flush_q.push_back(rval);
        else if (t_we) flush_q.push_back(pc + 32'd4);
        exp_flush = t_int | t_exc | t_ertn | t_we;
        if (t_int) exp_int++;
        if (t_exc) exp_exc++;
        @(posedge clk);
        #1;
        idle_inputs();
        #0;
        chk("pulse_cleared", {wb_ex, csr_we, csr_re, ertn_flush}, 4'b0);
        chk("wb_ready_after", wb_ready, !exp_flush);
    endtask

    // Hold off ack for a few cycles, confirm backpressure, then release.
    task automatic ack_flush();
        repeat (2) begin
            @(negedge clk);
            chk("flush_req_held", flush_req, 1);
            chk("wb_ready_blocked", wb_ready, 0);
        end
        flush_ack = 1;
        @(posedge clk);
        #1 flush_ack = 0;
        chk("flush_req_released", flush_req, 0);
        chk("wb_ready_released", wb_ready, 1);
    endtask

    logic f;

    initial begin
        idle_inputs();
        resetn = 0;
        #1;
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_flush_req", flush_req, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        repeat (2) @(negedge clk);
        resetn = 1;

        issue(3'd0, 32'h1C00_0000, 14'h0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 0, f);
        chk("none_no_flush", f, 0);
        issue(3'd1, 32'h1C00_0004, 14'h005, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, f);
        issue(3'd3, 32'h1C00_0010, 14'h030, 32'hAAAA_5555, 32'h0000_FFFF, 0, 0, 0, 0, 0,
              32'h1234_5678, 0, f);
        ack_flush();
        issue(3'd0, 32'h1C00_0020, 14'h0, 0, 0, 1, 6'h0D, 9'h3, 32'h0000_BEEF, 0, 0,
              32'h1C00_8000, f);
        ack_flush();
        issue(3'd2, 32'h1C00_0030, 14'h001, 32'h5, 0, 1, 6'h0B, 0, 0, 1, 32'h77, 32'h1C00_8000, f);
        ack_flush();
        issue(3'd4, 32'h1C00_0040, 14'h0, 0, 0, 0, 0, 0, 0, 0, 32'h1C00_0100, 0, f);
        ack_flush();
        issue(3'd6, 32'h1C00_0050, 14'h010, 32'h9, 32'h9, 0, 0, 0, 0, 0, 32'h42, 0, f);
        chk("kind6_no_flush", f, 0);

        @(negedge clk);
        wb_valid = 0; wb_kind = 3'd2; wb_ex_in = 1; has_int = 1;
        #1;
        chk("novalid_pulses", {wb_ex, csr_we, csr_re, ertn_flush}, 4'b0);
        idle_inputs();

        issue(3'd0, 32'h1C00_0060, 0, 0, 0, 1, 6'h08, 0, 32'h1C00_0061, 0, 0, 32'h1C00_9000, f);
        ack_flush();
        issue(3'd1, 32'h1C00_0070, 0, 0, 0, 1, 6'h0C, 9'h1, 0, 0, 0, 32'h1C00_9100, f);
        ack_flush();
        issue(3'd0, 32'h1C00_0080, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1C00_9200, f);
        ack_flush();

        @(negedge clk);
        flush_ack = 1;
        @(negedge clk);
        chk("ack_in_idle_ready", wb_ready, 1);
        chk("ack_in_idle_req", flush_req, 0);
        flush_ack = 0;

        issue(3'd2, 32'hFFFF_FFFC, 14'h002, 32'h1, 0, 0, 0, 0, 0, 0, 32'hCAFE_0000, 0, f);
        @(posedge clk);
        #3;
        chk("wrap_in_flush", flush_req, 1);
        resetn = 0;
        #1;
        chk("midflush_rst_req", flush_req, 0);
        chk("midflush_rst_ready", wb_ready, 1);
        chk("midflush_rst_pc", flush_pc, 0);
        @(negedge clk);
        resetn = 1;
`ifdef EXC_COMMIT_PERF_EN
        chk("perf_exc_after_rst", perf_exc_cnt, 0);
        chk("perf_int_after_rst", perf_int_cnt, 0);
`endif

`ifdef EXC_COMMIT_PERF_EN
        exp_exc = 0; exp_int = 0;
        issue(3'd0, 32'h100, 0, 0, 0, 1, 6'h09, 0, 0, 0, 0, 32'h200, f); ack_flush();
        issue(3'd0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, f);     ack_flush();
        issue(3'd0, 32'h108, 0, 0, 0, 1, 6'h0B, 0, 0, 0, 0, 32'h200, f); ack_flush();
        issue(3'd0, 32'h10C, 0, 0, 0, 1, 6'h0C, 0, 0, 1, 0, 32'h200, f); ack_flush();
        issue(3'd0, 32'h110, 0, 0, 0, 1, 6'h0D, 0, 0, 0, 0, 32'h200, f); ack_flush();
        chk("perf_exc_cnt", perf_exc_cnt, exp_exc);
        chk("perf_int_cnt", perf_int_cnt, exp_int);
        chk("perf_exc_is_3", exp_exc, 3);
`endif

        repeat (2) @(negedge clk);
        chk("rf_q_drained", rf_q.size(), 0);
        chk("flush_q_drained", flush_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
